// File: rtl/ps2_frame_receiver.sv
// ============================================================================
//  Module   : ps2_frame_receiver
//  Brief    : PS/2 serial frame receiver with synchronisers, kclk glitch
//             filter, odd-parity/stop checking and a mid-frame watchdog.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_frame_receiver #(
    parameter int FILTER_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        kclk,
    input  logic        kdata,
    output logic [15:0] keycode,
    output logic [7:0]  byte_out,
    output logic        oflag,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int FW = $clog2(FILTER_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic          kclk_s1, kclk_s2, kdata_s1, kdata_s2;
    logic          kclk_f, kclk_f_d;
    logic [FW-1:0] filt_cnt;
    logic          fall;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par_bit;
    logic [WW-1:0] wd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kclk_s1  <= 1'b1;
            kclk_s2  <= 1'b1;
            kdata_s1 <= 1'b1;
            kdata_s2 <= 1'b1;
        end else begin
            kclk_s1  <= kclk;
            kclk_s2  <= kclk_s1;
            kdata_s1 <= kdata;
            kdata_s2 <= kdata_s1;
        end
    end

    // A new kclk level is accepted on its FILTER_CYCLES-th consecutive cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kclk_f   <= 1'b1;
            kclk_f_d <= 1'b1;
            filt_cnt <= '0;
        end else begin
            kclk_f_d <= kclk_f;
            if (kclk_s2 != kclk_f) begin
                if (filt_cnt == FW'(FILTER_CYCLES - 1)) begin
                    kclk_f   <= kclk_s2;
                    filt_cnt <= '0;
                end else begin
                    filt_cnt <= filt_cnt + 1'b1;
                end
            end else begin
                filt_cnt <= '0;
            end
        end
    end

    assign fall = kclk_f_d & ~kclk_f;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            wd       <= '0;
            keycode  <= '0;
            byte_out <= '0;
            oflag    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            oflag <= 1'b0;
            err   <= 1'b0;
            // Timeout outranks a coincident falling edge.
            if (state != IDLE && wd == WW'(TIMEOUT_CYCLES)) begin
                state    <= IDLE;
                wd       <= '0;
                err      <= 1'b1;
                err_code <= 2'b11;
            end else begin
                if (state != IDLE)
                    wd <= fall ? '0 : wd + 1'b1;
                if (fall) begin
                    case (state)
                        IDLE: begin
                            if (!kdata_s2) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                shreg   <= '0;
                                wd      <= '0;
                            end
                        end
                        DATA: begin
                            shreg   <= {kdata_s2, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7)
                                state <= PARITY;
                        end
                        PARITY: begin
                            par_bit <= kdata_s2;
                            state   <= STOP;
                        end
                        STOP: begin
                            state <= IDLE;
                            wd    <= '0;
                            if (!(^{shreg, par_bit})) begin
                                err      <= 1'b1;
                                err_code <= 2'b01;
                            end else if (!kdata_s2) begin
                                err      <= 1'b1;
                                err_code <= 2'b10;
                            end else begin
                                keycode  <= {keycode[7:0], shreg};
                                byte_out <= shreg;
                                oflag    <= 1'b1;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire
